icache_responder: RTL and testbench

//  Responder side of the fetch-stage instruction read port: accepts instr_read/instr_address each cycle and

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_ram.sv | 39 +++
 rtl/icache_responder.sv | 144 ++++++++++++++
 tb/tb_icache_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// The fetch-path NOP encoding is defined here when the opcode header is absent.
`ifndef INSTR_NOP
`define INSTR_NOP 64'h0000_0000_0000_0013
`endif

package icache_pkg;

    localparam int ICACHE_LINES          = 64;
    localparam int ICACHE_WORDS_PER_LINE = 4;
    localparam int ICACHE_ADDR_W         = 64;
    localparam int ICACHE_DATA_W         = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        REPLAY = 2'd3
    } state_t;

    // Tag width left over once the byte offset, word select and index are removed.
    function automatic int tag_bits(input int addr_w, input int lines, input int words);
        return addr_w - 3 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_ram.sv
// Synchronous 1R1W data and tag arrays for the instruction cache.
// Reads return the pre-write contents when a read and write hit the same entry.
module icache_ram
    import icache_pkg::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
    parameter int TAG_W          = 53
) (
    input  logic                                          clk,
    input  logic [$clog2(LINES)+$clog2(WORDS_PER_LINE)-1:0] rd_addr,
    output logic [ICACHE_DATA_W-1:0]                      rd_data,
    output logic [TAG_W-1:0]                              rd_tag,
    input  logic                                          data_we,
    input  logic [$clog2(LINES)+$clog2(WORDS_PER_LINE)-1:0] data_waddr,
    input  logic [ICACHE_DATA_W-1:0]                      data_wdata,
    input  logic                                          tag_we,
    input  logic [$clog2(LINES)-1:0]                      tag_waddr,
    input  logic [TAG_W-1:0]                              tag_wdata
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);

    logic [ICACHE_DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]         tag_mem  [LINES];

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[tag_waddr] <= tag_wdata;
        end
        rd_data <= data_mem[rd_addr];
        rd_tag  <= tag_mem[rd_addr[IB+WB-1:WB]];
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch reads with one-cycle latency.
// Misses stall fetch, refill one line from memory, then replay the latched address.
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
    parameter int ADDR_W         = ICACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_read_in,
    input  logic [ADDR_W-1:0] instr_address_in,
    input  logic              invalidate_in,
    output logic [63:0]       instr_read_value_out,
    output logic              stall_out,
    output logic              mem_req_valid_out,
    input  logic              mem_req_ready_in,
    output logic [ADDR_W-1:0] mem_req_addr_out,
    input  logic              mem_resp_valid_in,
    input  logic [63:0]       mem_resp_data_in
);

    localparam int WB    = $clog2(WORDS_PER_LINE);
    localparam int IB    = $clog2(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINES, WORDS_PER_LINE);

    state_t               state_q, state_d;
    logic [ADDR_W-4:0]    lat_addr_q;
    logic                 lk_q;
    logic [WB-1:0]        beat_q;
    logic [LINES-1:0]     valid_q;
    logic                 inv_pend_q;
    logic [ADDR_W-1:0]    req_addr_q;

    logic [IB-1:0]        idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic [63:0]          rd_data;
    logic [TAG_W-1:0]     rd_tag;
    logic [IB+WB-1:0]     rd_addr;
    logic                 hit, miss, accept, beat_in, last_beat;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^instr_address_in[2:0];

    assign idx_q = lat_addr_q[WB +: IB];
    assign tag_q = lat_addr_q[ADDR_W-4 -: TAG_W];

    // lk_q marks the compare cycle following an array read; it is only ever set while IDLE.
    assign hit       = lk_q && valid_q[idx_q] && (rd_tag == tag_q);
    assign miss      = lk_q && !hit;
    assign accept    = (state_q == IDLE) && instr_read_in && !miss;
    assign beat_in   = (state_q == FILL) && mem_resp_valid_in;
    assign last_beat = beat_in && (beat_q == WB'(WORDS_PER_LINE - 1));
    assign rd_addr   = (state_q == REPLAY) ? lat_addr_q[IB+WB-1:0]
                                           : instr_address_in[3 +: IB+WB];

    icache_ram #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_ram (
        .clk        (clk),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_tag     (rd_tag),
        .data_we    (beat_in),
        .data_waddr ({idx_q, beat_q}),
        .data_wdata (mem_resp_data_in),
        .tag_we     (last_beat),
        .tag_waddr  (idx_q),
        .tag_wdata  (tag_q)
    );

    // Refill request: valid is raised in REQ and, with the address, held unchanged
    // until the cycle ready is sampled high; that edge completes the handshake.
    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    stall_out = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (mem_req_ready_in) state_d = FILL;
            end
            FILL: begin
                stall_out = 1'b1;
                if (last_beat) state_d = REPLAY;
            end
            REPLAY: begin
                stall_out = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_read_value_out = hit ? rd_data : `INSTR_NOP;
    assign mem_req_valid_out    = (state_q == REQ);
    assign mem_req_addr_out     = req_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lat_addr_q <= '0;
            lk_q       <= 1'b0;
            beat_q     <= '0;
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= accept || (state_q == REPLAY);
            if (accept) begin
                lat_addr_q <= instr_address_in[ADDR_W-1:3];
            end
            if (miss) begin
                req_addr_q <= {lat_addr_q[ADDR_W-4:WB], {(3+WB){1'b0}}};
            end
            if ((state_q == REQ) && mem_req_ready_in) begin
                beat_q <= '0;
            end else if (beat_in) begin
                beat_q <= beat_q + 1'b1;
            end
            // A fence.i seen at any point of a refill keeps the refilled line invalid.
            if (miss) begin
                inv_pend_q <= 1'b0;
            end else if (invalidate_in) begin
                inv_pend_q <= 1'b1;
            end
            if (invalidate_in) begin
                valid_q <= '0;
            end else if (last_beat && !inv_pend_q) begin
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Randomized bench for icache_responder against a line-granular cache model
// and a deterministic backing memory.
module tb_icache_responder;

    localparam int LINES = 64;
    localparam int WPL   = 4;
    localparam int LINE_BYTES = WPL * 8;
    localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_read_in;
    logic [63:0] instr_address_in;
    logic        invalidate_in;
    logic [63:0] instr_read_value_out;
    logic        stall_out;
    logic        mem_req_valid_out;
    logic        mem_req_ready_in;
    logic [63:0] mem_req_addr_out;
    logic        mem_resp_valid_in;
    logic [63:0] mem_resp_data_in;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    bit          model_valid [LINES];
    logic [63:0] model_line  [LINES];

    always #5 clk = ~clk;

    icache_responder dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .invalidate_in        (invalidate_in),
        .instr_read_value_out (instr_read_value_out),
        .stall_out            (stall_out),
        .mem_req_valid_out    (mem_req_valid_out),
        .mem_req_ready_in     (mem_req_ready_in),
        .mem_req_addr_out     (mem_req_addr_out),
        .mem_resp_valid_in    (mem_resp_valid_in),
        .mem_resp_data_in     (mem_resp_data_in)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_F00D, a[31:0] + 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return model_valid[idx_of(a)] && (model_line[idx_of(a)] == line_of(a));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_invalidate();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Services one refill: wait for the request, apply backpressure, deliver the beats.
    task automatic serve_refill(input logic [63:0] line, input int bp, input int inval_beat);
        int g;
        int k;
        tick();
        g = 0;
        while (!mem_req_valid_out && g < 50) begin
            tick();
            g++;
        end
        check("req_valid", mem_req_valid_out, 1);
        check("req_addr", mem_req_addr_out, line);
        check("req_stall", stall_out, 1);
        k = (bp < 0) ? $urandom_range(0, 3) : bp;
        for (int i = 0; i < k; i++) begin
            instr_read_in     = 1'b1;
            instr_address_in  = {$urandom, $urandom};
            mem_resp_valid_in = 1'($urandom_range(0, 1));
            mem_resp_data_in  = {$urandom, $urandom};
            tick();
            check("req_hold_valid", mem_req_valid_out, 1);
            check("req_hold_addr", mem_req_addr_out, line);
            check("req_hold_stall", stall_out, 1);
        end
        mem_resp_valid_in = 1'b0;
        mem_req_ready_in  = 1'b1;
        tick();
        mem_req_ready_in  = 1'b0;
        check("req_drop", mem_req_valid_out, 0);
        for (int b = 0; b < WPL; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            mem_resp_valid_in = 1'b1;
            mem_resp_data_in  = mem_word(line + 64'(8 * b));
            invalidate_in     = (b == inval_beat);
            if (b == WPL - 1) instr_read_in = 1'b0;
            tick();
            mem_resp_valid_in = 1'b0;
            invalidate_in     = 1'b0;
            if (b == inval_beat) model_invalidate();
        end
        model_line[idx_of(line)] = line;
        if (inval_beat < 0) model_valid[idx_of(line)] = 1'b1;
    endtask

    task automatic do_read(input logic [63:0] addr, input int bp, input int inval_beat);
        bit hit;
        bit done;
        int reqs;
        hit = model_hit(addr);
        exp_q.push_back(mem_word(addr & ~64'h7));
        instr_read_in    = 1'b1;
        instr_address_in = addr;
        tick();
        instr_read_in = 1'b0;
        if (hit) begin
            check("hit_stall", stall_out, 0);
            check("hit_noreq", mem_req_valid_out, 0);
            check("hit_value", instr_read_value_out, exp_q.pop_front());
        end else begin
            check("miss_stall", stall_out, 1);
            check("miss_value", instr_read_value_out, NOP);
            reqs = 0;
            done = 1'b0;
            while (!done && reqs < 3) begin
                serve_refill(line_of(addr), bp, (reqs == 0) ? inval_beat : -1);
                reqs++;
                check("replay_stall", stall_out, 1);
                tick();
                done = !stall_out;
            end
            check("refill_count", 64'(reqs), (inval_beat >= 0) ? 64'd2 : 64'd1);
            check("miss_release", stall_out, 0);
            check("miss_value_final", instr_read_value_out, exp_q.pop_front());
        end
    endtask

    task automatic do_idle();
        instr_read_in = 1'b0;
        tick();
        check("idle_value", instr_read_value_out, NOP);
        check("idle_stall", stall_out, 0);
    endtask

    task automatic do_invalidate();
        instr_read_in = 1'b0;
        invalidate_in = 1'b1;
        tick();
        invalidate_in = 1'b0;
        model_invalidate();
        check("inval_value", instr_read_value_out, NOP);
    endtask

    task automatic reset_during_fill(input logic [63:0] addr);
        int g;
        instr_read_in    = 1'b1;
        instr_address_in = addr;
        tick();
        instr_read_in = 1'b0;
        check("rf_miss_stall", stall_out, 1);
        tick();
        g = 0;
        while (!mem_req_valid_out && g < 50) begin
            tick();
            g++;
        end
        check("rf_req_addr", mem_req_addr_out, line_of(addr));
        mem_req_ready_in = 1'b1;
        tick();
        mem_req_ready_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid_in = 1'b1;
            mem_resp_data_in  = mem_word(line_of(addr) + 64'(8 * b));
            tick();
        end
        mem_resp_valid_in = 1'b0;
        reset_n = 1'b0;
        #1;
        model_invalidate();
        check("rf_stall", stall_out, 0);
        check("rf_value", instr_read_value_out, NOP);
        check("rf_req_valid", mem_req_valid_out, 0);
        check("rf_req_addr_zero", mem_req_addr_out, 0);
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = {$urandom, $urandom};
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            mem_resp_data_in = {$urandom, $urandom};
            tick();
            check("stray_stall", stall_out, 0);
            check("stray_req", mem_req_valid_out, 0);
        end
        mem_resp_valid_in = 1'b0;
    endtask

    initial begin
        reset_n           = 1'b0;
        instr_read_in     = 1'b0;
        instr_address_in  = '0;
        invalidate_in     = 1'b0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        model_invalidate();
        repeat (3) tick();
        check("rst_stall", stall_out, 0);
        check("rst_value", instr_read_value_out, NOP);
        check("rst_req_valid", mem_req_valid_out, 0);
        check("rst_req_addr", mem_req_addr_out, 0);
        reset_n = 1'b1;
        tick();

        do_read(64'h1000, 0, -1);
        do_read(64'h1008, 0, -1);
        do_read(64'h1018, 0, -1);
        do_idle();
        do_read(64'h3040, 5, -1);
        do_read(64'h1000 + LINES * 32, -1, -1);
        do_read(64'h1000, -1, -1);
        do_read(64'h1010, -1, -1);
        do_invalidate();
        do_read(64'h1000, -1, -1);
        do_read(64'h1040, -1, WPL - 1);
        do_read(64'h1048, -1, -1);
        do_read(64'h10A0, -1, 1);
        do_read(64'h10B8, -1, -1);
        do_invalidate();
        reset_during_fill(64'h2000);
        do_read(64'h2000, -1, -1);
        do_read(64'h1008, -1, -1);
        do_read(64'h2018, -1, -1);

        for (int n = 0; n < 200; n++) begin
            int r;
            logic [63:0] a;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_invalidate();
            end else if (r < 10) begin
                do_idle();
            end else begin
                a = 64'h1_0000 * 64'($urandom_range(1, 3))
                  + 64'(LINE_BYTES * $urandom_range(0, 7))
                  + 64'(8 * $urandom_range(0, WPL - 1));
                do_read(a, -1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WPL - 1)) : -1);
            end
        end

        do_idle();
        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
